// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store pipe: function codes, FSM states
// and access-size decode.
package lsu_pkg;

  localparam logic [3:0] FUNC_LB  = 4'b0000;
  localparam logic [3:0] FUNC_LH  = 4'b0001;
  localparam logic [3:0] FUNC_LW  = 4'b0010;
  localparam logic [3:0] FUNC_LBU = 4'b0100;
  localparam logic [3:0] FUNC_LHU = 4'b0101;
  localparam logic [3:0] FUNC_SB  = 4'b1000;
  localparam logic [3:0] FUNC_SH  = 4'b1001;
  localparam logic [3:0] FUNC_SW  = 4'b1010;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BEAT0 = 2'd1,
    ST_BEAT1 = 2'd2,
    ST_RESP  = 2'd3
  } lsu_state_t;

  // Access size in bytes; 0 marks an illegal function code.
  function automatic logic [2:0] func_size(input logic [3:0] func);
    case (func)
      FUNC_LB, FUNC_LBU, FUNC_SB: func_size = 3'd1;
      FUNC_LH, FUNC_LHU, FUNC_SH: func_size = 3'd2;
      FUNC_LW, FUNC_SW:           func_size = 3'd4;
      default:                    func_size = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane alignment: store data/byte-enable shifting across a two-word window,
// boundary-crossing detection and load gather with zero/sign extension.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned MEM_W = 64
) (
  input  logic [3:0]                   func,
  input  logic [$clog2(MEM_W/8)-1:0]   off,
  input  logic [XLEN-1:0]              wdata,
  input  logic [MEM_W-1:0]             rdata_lo,
  input  logic [MEM_W-1:0]             rdata_hi,
  output logic [MEM_W/8-1:0]           be_lo_c,
  output logic [MEM_W/8-1:0]           be_hi_c,
  output logic [MEM_W-1:0]             wdata_lo_c,
  output logic [MEM_W-1:0]             wdata_hi_c,
  output logic                         split_c,
  output logic [XLEN-1:0]              ldata_c
);

  localparam int unsigned BYTES = MEM_W / 8;
  localparam int unsigned OFF_W = $clog2(BYTES);
  localparam int unsigned SUM_W = OFF_W + 2;
  localparam int unsigned SH_W  = $clog2(XLEN) + 1;

  logic [2:0]              size;
  logic [OFF_W+2:0]        lsh;
  logic [2*BYTES-1:0]      be_base;
  logic [2*BYTES-1:0]      be_w;
  logic [2*MEM_W-1:0]      wd_w;
  logic [XLEN-1:0]         wmask;
  logic [XLEN-1:0]         raw;
  logic [XLEN-1:0]         tmp;
  logic signed [XLEN-1:0]  sext;
  logic [SH_W-1:0]         sh;

  always_comb begin
    size    = func_size(func);
    lsh     = {off, 3'b000};
    be_base = '0;
    wmask   = '0;
    sh      = SH_W'(XLEN - 32);
    case (size)
      3'd1: begin
        be_base = (2*BYTES)'(4'b0001);
        wmask   = XLEN'(8'hFF);
        sh      = SH_W'(XLEN - 8);
      end
      3'd2: begin
        be_base = (2*BYTES)'(4'b0011);
        wmask   = XLEN'(16'hFFFF);
        sh      = SH_W'(XLEN - 16);
      end
      3'd4: begin
        be_base = (2*BYTES)'(4'b1111);
        wmask   = XLEN'(32'hFFFF_FFFF);
        sh      = SH_W'(XLEN - 32);
      end
      default: begin
        be_base = '0;
        wmask   = '0;
      end
    endcase

    // Two-word window: the low word is beat0, the high word is beat1.
    be_w = be_base << off;
    wd_w = (2*MEM_W)'(wdata & wmask) << lsh;
    {be_hi_c, be_lo_c}       = be_w;
    {wdata_hi_c, wdata_lo_c} = wd_w;
    split_c = (SUM_W'(off) + SUM_W'(size)) > SUM_W'(BYTES);

    // Gather, then extend by shifting the field to the top and back down.
    raw     = XLEN'({rdata_hi, rdata_lo} >> lsh);
    tmp     = raw << sh;
    sext    = $signed(tmp) >>> sh;
    ldata_c = func[2] ? (tmp >> sh) : sext;
  end

endmodule

// File: rtl/lsu_pipe.sv
// Load/store unit: accepts one request at a time, issues one or two memory
// beats (splitting word-boundary crossings) and returns a single response.
module lsu_pipe
  import lsu_pkg::*;
#(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned MEM_W          = 64,
  parameter int unsigned ALLOW_MISALIGN = 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                req_valid,
  output logic                                req_ready,
  input  logic [3:0]                          req_func,
  input  logic [XLEN-1:0]                     req_base,
  input  logic [11:0]                         req_offset,
  input  logic [XLEN-1:0]                     req_wdata,
  output logic                                rsp_valid,
  output logic [XLEN-1:0]                     rsp_data,
  output logic                                rsp_fault,
  output logic                                mem_req,
  output logic                                mem_we,
  output logic [XLEN-$clog2(MEM_W/8)-1:0]     mem_addr,
  output logic [MEM_W/8-1:0]                  mem_be,
  output logic [MEM_W-1:0]                    mem_wdata,
  input  logic                                mem_ack,
  input  logic [MEM_W-1:0]                    mem_rdata
);

  localparam int unsigned BYTES  = MEM_W / 8;
  localparam int unsigned OFF_W  = $clog2(BYTES);
  localparam int unsigned ADDR_W = XLEN - OFF_W;

  lsu_state_t        state;
  logic [3:0]        func_q;
  logic [OFF_W-1:0]  off_q;
  logic [XLEN-1:0]   wdata_q;
  logic [MEM_W-1:0]  rdata_q;
  logic              split_q;

  logic [XLEN-1:0]   ea_c;
  logic [3:0]        a_func;
  logic [OFF_W-1:0]  a_off;
  logic [XLEN-1:0]   a_wdata;
  logic [MEM_W-1:0]  a_rlo;
  logic [BYTES-1:0]  be_lo_c, be_hi_c;
  logic [MEM_W-1:0]  wdata_lo_c, wdata_hi_c;
  logic              split_c;
  logic [XLEN-1:0]   ldata_c;
  logic              fault_c;

  // The aligner sees the live request in IDLE and the captured one afterwards.
  always_comb begin
    ea_c    = req_base + {{(XLEN-12){req_offset[11]}}, req_offset};
    a_func  = (state == ST_IDLE) ? req_func : func_q;
    a_off   = (state == ST_IDLE) ? ea_c[OFF_W-1:0] : off_q;
    a_wdata = (state == ST_IDLE) ? req_wdata : wdata_q;
    a_rlo   = (state == ST_BEAT1) ? rdata_q : mem_rdata;
    fault_c = (func_size(req_func) == 3'd0) ||
              (split_c && (ALLOW_MISALIGN == 0));
  end

  lsu_align #(.XLEN(XLEN), .MEM_W(MEM_W)) u_align (
    .func       (a_func),
    .off        (a_off),
    .wdata      (a_wdata),
    .rdata_lo   (a_rlo),
    .rdata_hi   (mem_rdata),
    .be_lo_c    (be_lo_c),
    .be_hi_c    (be_hi_c),
    .wdata_lo_c (wdata_lo_c),
    .wdata_hi_c (wdata_hi_c),
    .split_c    (split_c),
    .ldata_c    (ldata_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_fault <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
      func_q    <= '0;
      off_q     <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      split_q   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_fault <= 1'b0;
      rsp_data  <= '0;
      case (state)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            func_q    <= req_func;
            off_q     <= ea_c[OFF_W-1:0];
            wdata_q   <= req_wdata;
            split_q   <= split_c;
            if (fault_c) begin
              state     <= ST_RESP;
              rsp_valid <= 1'b1;
              rsp_fault <= 1'b1;
            end else begin
              state     <= ST_BEAT0;
              mem_req   <= 1'b1;
              mem_we    <= req_func[3];
              mem_addr  <= ea_c[XLEN-1:OFF_W];
              mem_be    <= req_func[3] ? be_lo_c : '1;
              mem_wdata <= req_func[3] ? wdata_lo_c : '0;
            end
          end
        end
        ST_BEAT0, ST_BEAT1: begin
          if (mem_ack) begin
            if (state == ST_BEAT0 && split_q) begin
              state     <= ST_BEAT1;
              rdata_q   <= mem_rdata;
              mem_addr  <= mem_addr + ADDR_W'(1);
              mem_be    <= func_q[3] ? be_hi_c : '1;
              mem_wdata <= func_q[3] ? wdata_hi_c : '0;
            end else begin
              state     <= ST_RESP;
              mem_req   <= 1'b0;
              mem_we    <= 1'b0;
              mem_addr  <= '0;
              mem_be    <= '0;
              mem_wdata <= '0;
              rsp_valid <= 1'b1;
              rsp_data  <= func_q[3] ? '0 : ldata_c;
            end
          end
        end
        ST_RESP: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_pipe.sv
// Directed bench for lsu_pipe: one instance with misalignment splitting,
// one with misalignment faulting, sharing the request payload inputs.
module tb_lsu_pipe;

  logic        clk;
  logic        rst;
  logic        req_valid, req_valid0;
  logic [3:0]  req_func;
  logic [31:0] req_base;
  logic [11:0] req_offset;
  logic [31:0] req_wdata;
  logic        mem_ack, mem_ack0;
  logic [63:0] mem_rdata;

  logic        req_ready, rsp_valid, rsp_fault, mem_req, mem_we;
  logic [31:0] rsp_data;
  logic [28:0] mem_addr;
  logic [7:0]  mem_be;
  logic [63:0] mem_wdata;

  logic        req_ready0, rsp_valid0, rsp_fault0, mem_req0, mem_we0;
  logic [31:0] rsp_data0;
  logic [28:0] mem_addr0;
  logic [7:0]  mem_be0;
  logic [63:0] mem_wdata0;

  int n_cmp  = 0;
  int n_fail = 0;

  lsu_pipe #(.XLEN(32), .MEM_W(64), .ALLOW_MISALIGN(1)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_func(req_func),
    .req_base(req_base), .req_offset(req_offset), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_fault(rsp_fault),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  lsu_pipe #(.XLEN(32), .MEM_W(64), .ALLOW_MISALIGN(0)) u_dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid0), .req_ready(req_ready0), .req_func(req_func),
    .req_base(req_base), .req_offset(req_offset), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid0), .rsp_data(rsp_data0), .rsp_fault(rsp_fault0),
    .mem_req(mem_req0), .mem_we(mem_we0), .mem_addr(mem_addr0), .mem_be(mem_be0),
    .mem_wdata(mem_wdata0), .mem_ack(mem_ack0), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Aligned load on the splitting instance, acked in its first beat cycle.
  task automatic do_load(input string tag, input logic [3:0] f, input logic [31:0] base,
                         input logic [11:0] off, input logic [63:0] rd,
                         input logic [28:0] exp_addr, input logic [31:0] exp_data);
    req_valid = 1'b1; req_func = f; req_base = base; req_offset = off;
    tick();
    req_valid = 1'b0;
    check({tag, "_req"},   64'(mem_req), 64'd1);
    check({tag, "_addr"},  64'(mem_addr), 64'(exp_addr));
    check({tag, "_be"},    64'(mem_be), 64'hFF);
    check({tag, "_we"},    64'(mem_we), 64'd0);
    check({tag, "_rdy"},   64'(req_ready), 64'd0);
    mem_ack = 1'b1; mem_rdata = rd;
    tick();
    check({tag, "_vld"},   64'(rsp_valid), 64'd1);
    check({tag, "_data"},  64'(rsp_data), 64'(exp_data));
    check({tag, "_flt"},   64'(rsp_fault), 64'd0);
    check({tag, "_reqlo"}, 64'(mem_req), 64'd0);
    mem_ack = 1'b0;
    tick();
    check({tag, "_vldlo"}, 64'(rsp_valid), 64'd0);
    check({tag, "_rdyhi"}, 64'(req_ready), 64'd1);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_valid0 = 1'b0; req_func = 4'b0000;
    req_base = '0; req_offset = '0; req_wdata = '0;
    mem_ack = 1'b0; mem_ack0 = 1'b0; mem_rdata = '0;
    tick();
    tick();
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_data",  64'(rsp_data), 64'd0);
    check("rst_rsp_fault", 64'(rsp_fault), 64'd0);
    check("rst_mem_req",   64'(mem_req), 64'd0);
    check("rst_mem_we",    64'(mem_we), 64'd0);
    check("rst_mem_addr",  64'(mem_addr), 64'd0);
    check("rst_mem_be",    64'(mem_be), 64'd0);
    check("rst_mem_wdata", mem_wdata, 64'd0);
    rst = 1'b0;
    tick();
    check("rst_ready",  64'(req_ready), 64'd1);
    check("rst_ready0", 64'(req_ready0), 64'd1);

    do_load("lw_al",   lsu_pkg::FUNC_LW,  32'h100, 12'd4,   64'hDEADBEEF_00000000, 29'h20, 32'hDEADBEEF);
    do_load("lb_sx",   lsu_pkg::FUNC_LB,  32'h103, 12'd0,   64'h00000000_80000000, 29'h20, 32'hFFFFFF80);
    do_load("lbu_zx",  lsu_pkg::FUNC_LBU, 32'h103, 12'd0,   64'h00000000_80000000, 29'h20, 32'h00000080);
    do_load("lh_neg",  lsu_pkg::FUNC_LH,  32'h10A, 12'hFFC, 64'hA55A0000_00000000, 29'h20, 32'hFFFFA55A);
    do_load("lhu_neg", lsu_pkg::FUNC_LHU, 32'h10A, 12'hFFC, 64'hA55A0000_00000000, 29'h20, 32'h0000A55A);

    // Split load at 0xFFFFFFFE: second beat wraps to word 0.
    req_valid = 1'b1; req_func = lsu_pkg::FUNC_LW; req_base = 32'h0; req_offset = 12'hFFE;
    tick();
    req_valid = 1'b0;
    check("lwsp_b0_req",  64'(mem_req), 64'd1);
    check("lwsp_b0_addr", 64'(mem_addr), 64'h1FFFFFFF);
    mem_ack = 1'b1; mem_rdata = 64'hBBAA0000_00000000;
    tick();
    check("lwsp_b1_req",  64'(mem_req), 64'd1);
    check("lwsp_b1_addr", 64'(mem_addr), 64'd0);
    check("lwsp_b1_be",   64'(mem_be), 64'hFF);
    check("lwsp_b1_vld",  64'(rsp_valid), 64'd0);
    mem_rdata = 64'h00000000_0000DDCC;
    tick();
    check("lwsp_vld",  64'(rsp_valid), 64'd1);
    check("lwsp_data", 64'(rsp_data), 64'hDDCCBBAA);
    check("lwsp_req",  64'(mem_req), 64'd0);
    mem_ack = 1'b0;
    tick();
    check("lwsp_vldlo", 64'(rsp_valid), 64'd0);

    // Split store at 0x106.
    req_valid = 1'b1; req_func = lsu_pkg::FUNC_SW; req_base = 32'h106; req_offset = 12'd0;
    req_wdata = 32'h11223344;
    tick();
    req_valid = 1'b0;
    check("swsp_b0_req",  64'(mem_req), 64'd1);
    check("swsp_b0_we",   64'(mem_we), 64'd1);
    check("swsp_b0_addr", 64'(mem_addr), 64'h20);
    check("swsp_b0_be",   64'(mem_be), 64'hC0);
    check("swsp_b0_wd",   mem_wdata, 64'h33440000_00000000);
    mem_ack = 1'b1;
    tick();
    check("swsp_b1_req",  64'(mem_req), 64'd1);
    check("swsp_b1_we",   64'(mem_we), 64'd1);
    check("swsp_b1_addr", 64'(mem_addr), 64'h21);
    check("swsp_b1_be",   64'(mem_be), 64'h03);
    check("swsp_b1_wd",   mem_wdata, 64'h00000000_00001122);
    check("swsp_b1_vld",  64'(rsp_valid), 64'd0);
    tick();
    check("swsp_vld",  64'(rsp_valid), 64'd1);
    check("swsp_data", 64'(rsp_data), 64'd0);
    check("swsp_flt",  64'(rsp_fault), 64'd0);
    check("swsp_req",  64'(mem_req), 64'd0);
    mem_ack = 1'b0;
    tick();
    check("swsp_vldlo", 64'(rsp_valid), 64'd0);

    // Aligned halfword store: upper wdata bytes must not reach the bus.
    req_valid = 1'b1; req_func = lsu_pkg::FUNC_SH; req_base = 32'h102; req_wdata = 32'hFFFFCAFE;
    tick();
    req_valid = 1'b0;
    check("sh_addr", 64'(mem_addr), 64'h20);
    check("sh_be",   64'(mem_be), 64'h0C);
    check("sh_wd",   mem_wdata, 64'h00000000_CAFE0000);
    mem_ack = 1'b1;
    tick();
    check("sh_vld",  64'(rsp_valid), 64'd1);
    check("sh_data", 64'(rsp_data), 64'd0);
    mem_ack = 1'b0;
    tick();

    // Illegal function on the splitting instance.
    req_valid = 1'b1; req_func = 4'b1100; req_base = 32'h100;
    tick();
    req_valid = 1'b0;
    check("ill_vld",  64'(rsp_valid), 64'd1);
    check("ill_flt",  64'(rsp_fault), 64'd1);
    check("ill_data", 64'(rsp_data), 64'd0);
    check("ill_req",  64'(mem_req), 64'd0);
    tick();
    check("ill_vldlo", 64'(rsp_valid), 64'd0);
    check("ill_rdy",   64'(req_ready), 64'd1);

    // Non-splitting instance: crossing sh and func 0011 both fault at T+1.
    req_valid0 = 1'b1; req_func = lsu_pkg::FUNC_SH; req_base = 32'h107;
    tick();
    req_valid0 = 1'b0;
    check("mis_vld",  64'(rsp_valid0), 64'd1);
    check("mis_flt",  64'(rsp_fault0), 64'd1);
    check("mis_data", 64'(rsp_data0), 64'd0);
    check("mis_req",  64'(mem_req0), 64'd0);
    tick();
    check("mis_vldlo", 64'(rsp_valid0), 64'd0);
    check("mis_rdy",   64'(req_ready0), 64'd1);
    req_valid0 = 1'b1; req_func = 4'b0011; req_base = 32'h100;
    tick();
    req_valid0 = 1'b0;
    check("f3_vld", 64'(rsp_valid0), 64'd1);
    check("f3_flt", 64'(rsp_fault0), 64'd1);
    check("f3_req", 64'(mem_req0), 64'd0);
    tick();
    check("f3_vldlo", 64'(rsp_valid0), 64'd0);

    // Aligned byte store on the non-splitting instance proceeds normally.
    req_valid0 = 1'b1; req_func = lsu_pkg::FUNC_SB; req_base = 32'h105; req_wdata = 32'h000000AB;
    tick();
    req_valid0 = 1'b0;
    check("sb0_req", 64'(mem_req0), 64'd1);
    check("sb0_we",  64'(mem_we0), 64'd1);
    check("sb0_be",  64'(mem_be0), 64'h20);
    check("sb0_wd",  mem_wdata0, 64'h0000AB00_00000000);
    mem_ack0 = 1'b1;
    tick();
    check("sb0_vld", 64'(rsp_valid0), 64'd1);
    check("sb0_flt", 64'(rsp_fault0), 64'd0);
    mem_ack0 = 1'b0;
    tick();

    // Stalled load abandoned by a reset in its third cycle.
    req_valid = 1'b1; req_func = lsu_pkg::FUNC_LW; req_base = 32'h200; req_offset = 12'd0;
    tick();
    req_valid = 1'b0;
    check("stall_c1_req",  64'(mem_req), 64'd1);
    check("stall_c1_addr", 64'(mem_addr), 64'h40);
    tick();
    check("stall_c2_req",  64'(mem_req), 64'd1);
    check("stall_c2_addr", 64'(mem_addr), 64'h40);
    tick();
    check("stall_c3_req",  64'(mem_req), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("stall_rst_req",  64'(mem_req), 64'd0);
    check("stall_rst_vld",  64'(rsp_valid), 64'd0);
    check("stall_rst_addr", 64'(mem_addr), 64'd0);
    check("stall_rst_be",   64'(mem_be), 64'd0);
    tick();
    check("stall_post_req", 64'(mem_req), 64'd0);
    check("stall_post_vld", 64'(rsp_valid), 64'd0);
    check("stall_post_rdy", 64'(req_ready), 64'd1);
    do_load("lw_post", lsu_pkg::FUNC_LW, 32'h100, 12'd4, 64'h12345678_00000000, 29'h20, 32'h12345678);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
